// File: rtl/divisor_pkg.sv
// Shared definitions for the sequential restoring divider.
package divisor_pkg;

  // Default operand width of the divider.
  localparam int N_BITS_DEF = 8;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } estado_t;

endpackage

// File: rtl/divisor_secuencial_if.sv
// Handshake and data bundle between a requester and the divider.
interface divisor_secuencial_if #(parameter int N = 8);

  logic         inicio;
  logic [N-1:0] dividendo;
  logic [N-1:0] divisor;
  logic [N-1:0] cociente;
  logic [N-1:0] resto;
  logic         listo;
  logic         ocupado;
  logic         div_cero;

  // Requester side: issues operands, observes results.
  modport master (
    output inicio, dividendo, divisor,
    input  cociente, resto, listo, ocupado, div_cero
  );

  // Divider side.
  modport slave (
    input  inicio, dividendo, divisor,
    output cociente, resto, listo, ocupado, div_cero
  );

endinterface

// File: rtl/restador_ext.sv
// Two's-complement subtractor: dif = a + ~b + 1.
module restador_ext #(
  parameter int W = 9
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] dif_o
);

  localparam logic [W-1:0] UNO = {{(W-1){1'b0}}, 1'b1};

  assign dif_o = a_i + ~b_i + UNO;

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential restoring divider, one quotient bit per clock.
//
//   state | meaning
//   IDLE  | waiting for inicio; operands captured on acceptance
//   CALC  | one restoring step per cycle, n_bits cycles
//   FIN   | publish result; listo rises on the edge leaving FIN
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int n_bits = N_BITS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  divisor_secuencial_if.slave bus
);

  localparam int              CW      = $clog2(n_bits + 1);
  localparam logic [CW-1:0]   CNT_INI = CW'(n_bits);
  localparam logic [CW-1:0]   CNT_UNO = CW'(1);

  estado_t           estado_q;
  logic [CW-1:0]     cnt_q;
  logic [n_bits-1:0] r_q;
  logic [n_bits-1:0] q_q;
  logic [n_bits-1:0] dsor_q;
  logic              dz_q;
  logic [n_bits-1:0] cociente_q;
  logic [n_bits-1:0] resto_q;
  logic              listo_q;
  logic              div_cero_q;

  logic [n_bits:0]   r_desp;
  logic [n_bits:0]   prueba;
  logic [n_bits-1:0] r_d;
  logic [n_bits-1:0] q_d;

  // The partial remainder always stays below the divisor, so its top bit
  // only exists in the shifted/trial values, not in the stored register.
  assign r_desp = {r_q, q_q[n_bits-1]};

  restador_ext #(.W(n_bits + 1)) u_restador (
    .a_i   (r_desp),
    .b_i   ({1'b0, dsor_q}),
    .dif_o (prueba)
  );

  // Restoring decision: a negative trial keeps the shifted remainder.
  always_comb begin
    r_d = r_desp[n_bits-1:0];
    q_d = {q_q[n_bits-2:0], 1'b0};
    if (!prueba[n_bits]) begin
      r_d = prueba[n_bits-1:0];
      q_d = {q_q[n_bits-2:0], 1'b1};
    end
  end

  // Control FSM with datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      q_q        <= '0;
      dsor_q     <= '0;
      dz_q       <= 1'b0;
      cociente_q <= '0;
      resto_q    <= '0;
      listo_q    <= 1'b0;
      div_cero_q <= 1'b0;
    end else begin
      listo_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (bus.inicio) begin
            if (bus.divisor == '0) begin
              // Result is fixed immediately; skip the iterations.
              q_q      <= '1;
              r_q      <= bus.dividendo;
              dz_q     <= 1'b1;
              estado_q <= FIN;
            end else begin
              q_q      <= bus.dividendo;
              r_q      <= '0;
              dsor_q   <= bus.divisor;
              cnt_q    <= CNT_INI;
              dz_q     <= 1'b0;
              estado_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CNT_UNO;
          if (cnt_q == CNT_UNO) begin
            estado_q <= FIN;
          end
        end
        FIN: begin
          listo_q    <= 1'b1;
          cociente_q <= q_q;
          resto_q    <= r_q;
          div_cero_q <= dz_q;
          estado_q   <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign bus.cociente = cociente_q;
  assign bus.resto    = resto_q;
  assign bus.listo    = listo_q;
  assign bus.div_cero = div_cero_q;
  assign bus.ocupado  = (estado_q != IDLE);

endmodule

// File: tb/tb_divisor_secuencial.sv
// Directed bench for the sequential divider at n_bits = 8.
module tb_divisor_secuencial;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  divisor_secuencial_if #(.N(8)) bus ();

  divisor_secuencial #(.n_bits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one request for a single cycle; return edges from the accepting
  // edge to listo, and the number of sampled cycles with ocupado high.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int occ);
    @(negedge clk);
    bus.inicio    = 1'b1;
    bus.dividendo = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    lat = 0;
    occ = 0;
    while (bus.listo !== 1'b1 && lat < 40) begin
      if (bus.ocupado === 1'b1) occ++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    n_total++;
    if ({bus.cociente, bus.resto, bus.listo, bus.ocupado, bus.div_cero} !== 19'd0)
      $display("FAIL reset_outputs: got q=%0d r=%0d listo=%b ocup=%b dz=%b, required all 0",
               bus.cociente, bus.resto, bus.listo, bus.ocupado, bus.div_cero);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (bus.ocupado !== 1'b0)
      $display("FAIL reset_idle: got ocupado=%b, required 0", bus.ocupado);
    else n_pass++;
  endtask

  task automatic test_basic();
    int lat, occ;
    do_op(8'd100, 8'd7, lat, occ);
    n_total++;
    if (lat !== 9) $display("FAIL basic_latency: got %0d, required 9", lat);
    else n_pass++;
    n_total++;
    if (occ !== 9) $display("FAIL basic_ocupado: got %0d cycles, required 9", occ);
    else n_pass++;
    n_total++;
    if ({bus.cociente, bus.resto, bus.div_cero} !== {8'd14, 8'd2, 1'b0})
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, required q=14 r=2 dz=0",
               bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (bus.listo !== 1'b0) $display("FAIL basic_pulse: got listo=%b, required 0", bus.listo);
    else n_pass++;
    repeat (5) @(posedge clk);
    #1;
    n_total++;
    if ({bus.cociente, bus.resto} !== {8'd14, 8'd2})
      $display("FAIL basic_hold: got q=%0d r=%0d, required q=14 r=2", bus.cociente, bus.resto);
    else n_pass++;
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'd255, 8'd5, 8'd250, 8'd1, 8'd0, 8'd254};
    logic [7:0] vb [6] = '{8'd1,   8'd9, 8'd10,  8'd1, 8'd3, 8'd255};
    logic [7:0] vq [6] = '{8'd255, 8'd0, 8'd25,  8'd1, 8'd0, 8'd0};
    logic [7:0] vr [6] = '{8'd0,   8'd5, 8'd0,   8'd0, 8'd0, 8'd254};
    int lat, occ;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], lat, occ);
      n_total++;
      if (lat !== 9 || {bus.cociente, bus.resto, bus.div_cero} !== {vq[i], vr[i], 1'b0})
        $display("FAIL vector_%0d: got lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=%0d r=%0d dz=0",
                 i, lat, bus.cociente, bus.resto, bus.div_cero, vq[i], vr[i]);
      else n_pass++;
    end
  endtask

  task automatic test_div_zero();
    int lat, occ;
    do_op(8'd37, 8'd0, lat, occ);
    n_total++;
    if (lat !== 1 || occ !== 1)
      $display("FAIL zero_latency: got lat=%0d ocup=%0d, required lat=1 ocup=1", lat, occ);
    else n_pass++;
    n_total++;
    if ({bus.cociente, bus.resto, bus.div_cero} !== {8'd255, 8'd37, 1'b1})
      $display("FAIL zero_result: got q=%0d r=%0d dz=%b, required q=255 r=37 dz=1",
               bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
    do_op(8'd20, 8'd4, lat, occ);
    n_total++;
    if (lat !== 9 || {bus.cociente, bus.resto, bus.div_cero} !== {8'd5, 8'd0, 1'b0})
      $display("FAIL zero_recover: got lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=5 r=0 dz=0",
               lat, bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
  endtask

  task automatic test_ignore_inicio();
    int lat, pulses;
    @(negedge clk);
    bus.inicio    = 1'b1;
    bus.dividendo = 8'd200;
    bus.divisor   = 8'd3;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    lat = 0;
    repeat (2) begin @(posedge clk); #1; lat++; end
    bus.inicio    = 1'b1;
    bus.dividendo = 8'd10;
    bus.divisor   = 8'd2;
    repeat (3) begin @(posedge clk); #1; lat++; end
    bus.inicio = 1'b0;
    while (bus.listo !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++;
    if (lat !== 9 || {bus.cociente, bus.resto, bus.div_cero} !== {8'd66, 8'd2, 1'b0})
      $display("FAIL ignore_result: got lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=66 r=2 dz=0",
               lat, bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.listo === 1'b1) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL ignore_single_pulse: got %0d extra pulses, required 0", pulses);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus.inicio    = 1'b1;
    bus.dividendo = 8'd50;
    bus.divisor   = 8'd5;
    @(posedge clk); #1;
    lat = 0;
    while (bus.listo !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++;
    if (lat !== 9 || {bus.cociente, bus.resto} !== {8'd10, 8'd0})
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d, required lat=9 q=10 r=0",
               lat, bus.cociente, bus.resto);
    else n_pass++;
    bus.dividendo = 8'd60;
    bus.divisor   = 8'd7;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    n_total++;
    if (bus.ocupado !== 1'b1) $display("FAIL b2b_accept: got ocupado=%b, required 1", bus.ocupado);
    else n_pass++;
    lat = 0;
    while (bus.listo !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    n_total++;
    if (lat !== 9 || {bus.cociente, bus.resto, bus.div_cero} !== {8'd8, 8'd4, 1'b0})
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=8 r=4 dz=0",
               lat, bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
  endtask

  task automatic test_reset_abort();
    int lat, occ, pulses;
    @(negedge clk);
    bus.inicio    = 1'b1;
    bus.dividendo = 8'd100;
    bus.divisor   = 8'd7;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if ({bus.cociente, bus.resto, bus.listo, bus.ocupado, bus.div_cero} !== 19'd0)
      $display("FAIL abort_outputs: got q=%0d r=%0d listo=%b ocup=%b dz=%b, required all 0",
               bus.cociente, bus.resto, bus.listo, bus.ocupado, bus.div_cero);
    else n_pass++;
    pulses = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.listo === 1'b1 || bus.ocupado === 1'b1) pulses++;
    end
    n_total++;
    if (pulses !== 0) $display("FAIL abort_no_listo: got %0d active cycles, required 0", pulses);
    else n_pass++;
    do_op(8'd9, 8'd2, lat, occ);
    n_total++;
    if (lat !== 9 || {bus.cociente, bus.resto, bus.div_cero} !== {8'd4, 8'd1, 1'b0})
      $display("FAIL abort_restart: got lat=%0d q=%0d r=%0d dz=%b, required lat=9 q=4 r=1 dz=0",
               lat, bus.cociente, bus.resto, bus.div_cero);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] a, b, eq, er;
    logic       edz;
    int         elat, lat, occ;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      case (i % 5)
        0: a = 8'd0;
        1: a = b;
        2: begin a = 8'd255; b = 8'd255; end
        default: ;
      endcase
      if (b == 8'd0) begin
        eq = 8'd255; er = a; edz = 1'b1; elat = 1;
      end else begin
        eq = a / b; er = a % b; edz = 1'b0; elat = 9;
      end
      do_op(a, b, lat, occ);
      n_total++;
      if (lat !== elat || {bus.cociente, bus.resto, bus.div_cero} !== {eq, er, edz})
        $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b, required lat=%0d q=%0d r=%0d dz=%b",
                 a, b, lat, bus.cociente, bus.resto, bus.div_cero, elat, eq, er, edz);
      else n_pass++;
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.inicio    = 1'b0;
    bus.dividendo = 8'd0;
    bus.divisor   = 8'd0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_inicio();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 Parameter n_bits, default 8, SHALL set the operand width; legal range 2..32.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 inicio  input  1  SHALL request a division; sampled only in state IDLE.
REQ-005 dividendo  input  n_bits  SHALL be the unsigned dividend; sampled with accepted inicio.
REQ-006 divisor  input  n_bits  SHALL be the unsigned divisor; sampled with accepted inicio.
REQ-007 cociente  output  n_bits  SHALL carry the quotient of the last completed operation.
REQ-008 resto  output  n_bits  SHALL carry the remainder of the last completed operation.
REQ-009 listo  output  1  SHALL pulse high for exactly one cycle when the result is valid.
REQ-010 ocupado  output  1  SHALL be high whenever state is not IDLE.
REQ-011 div_cero  output  1  SHALL flag that the last completed operation had divisor 0.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIN.
REQ-013 IDLE, inicio=1, divisor!=0: operands latched, partial remainder R (n_bits+1 bits) cleared, Q loaded with dividendo, iteration counter loaded with n_bits, next state CALC.
REQ-014 IDLE, inicio=1, divisor=0: next state FIN; result fixed as cociente=all ones, resto=dividendo, div_cero=1.
REQ-015 Each CALC cycle SHALL perform one restoring step: shift {R,Q} left by 1; trial = R_shifted - {0,divisor} on one shared n_bits+1-bit subtractor; trial MSB=0 keeps trial and sets Q LSB to 1, otherwise keeps R_shifted and sets Q LSB to 0.
REQ-016 Counter SHALL decrement once per CALC cycle; CALC SHALL last exactly n_bits cycles, then next state FIN.
REQ-017 FIN SHALL drive listo=1 for one cycle, update cociente/resto/div_cero, and return to IDLE unconditionally.
REQ-018 Latency: listo SHALL be high in the cycle starting n_bits+1 edges after the accepting edge (nonzero divisor), 1 edge after (zero divisor).
REQ-019 cociente, resto, div_cero SHALL hold their values from FIN until the next FIN.
REQ-020 inicio while ocupado=1 SHALL be ignored and not queued; inicio in the FIN cycle SHALL be ignored.
REQ-021 Changes on dividendo/divisor after the accepting edge SHALL NOT affect the running operation.
REQ-022 Back-to-back: inicio held high SHALL start a new operation on the first IDLE cycle after FIN.

Reset
REQ-023 reset=1 SHALL immediately force state IDLE, counter 0, internal R/Q 0, regardless of clk.
REQ-024 Reset values: cociente=0, resto=0, listo=0, ocupado=0, div_cero=0.
REQ-025 Reset during CALC or FIN SHALL abort the operation with no listo pulse; first start SHALL be accepted on the first clk edge after reset deasserts.

Structure
REQ-026 Shared package divisor_pkg SHALL hold the state enum typedef (IDLE, CALC, FIN) and the default width constant.
REQ-027 Subtraction SHALL live in one sub-module restador_ext (two's-complement a + ~b + 1, parameterized width), instantiated once at n_bits+1.
REQ-028 Counter width SHALL be $clog2(n_bits+1) bits.

Verification
REQ-029 n_bits=8, 100/7, inicio for 1 cycle -> ocupado 8+1 cycles, listo pulse 9 edges after start, cociente=14, resto=2, div_cero=0.
REQ-030 255/1 -> cociente=255, resto=0; 5/9 -> cociente=0, resto=5.
REQ-031 37/0 -> listo 1 edge after start, cociente=255, resto=37, div_cero=1; next 20/4 -> 5 r0, div_cero=0.
REQ-032 Start 200/3, re-assert inicio with 10/2 and change operands during CALC -> result 66 r2, single listo pulse.
REQ-033 Start 100/7, assert reset at 4th CALC cycle -> all outputs 0 immediately, no listo; then 9/2 -> 4 r1 with normal latency.
REQ-034 Random sweep of 1000 operand pairs incl. 0/x, x/x, max/max -> cociente*divisor+resto=dividendo and resto<divisor for divisor!=0.
